// File: rtl/tracker_pkg.sv
// Shared types and defaults for the paddle bounding-box tracker.
package tracker_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int COORD_W      = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMMIT
    } tracker_state_t;

endpackage

// File: rtl/run_filter.sv
// Horizontal run-length qualifier: flags the pixel where a target run reaches
// RUN_MIN and every later pixel of that same run.
module run_filter
    import tracker_pkg::*;
#(
    parameter int RUN_MIN = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   de,
    input  coord_t x,
    input  logic   is_target,
    output logic   qualify_first,
    output logic   qualify_cont
);

    localparam int RUN_W = $clog2(RUN_MIN + 1);

    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_base;
    logic [RUN_W-1:0] run_next;
    logic             hit;

    always_comb begin
        hit      = de && is_target;
        // Column 0 starts a fresh row, so the previous row's run never carries over.
        run_base = (x == '0) ? '0 : run_len;
        run_next = '0;
        if (hit) begin
            run_next = (run_base == RUN_W'(RUN_MIN)) ? run_base : run_base + 1'b1;
        end
        qualify_first = enable && hit && (run_base == RUN_W'(RUN_MIN - 1));
        qualify_cont  = enable && hit && (run_base == RUN_W'(RUN_MIN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len <= '0;
        end else if (enable) begin
            run_len <= run_next;
        end
    end

endmodule

// File: rtl/target_tracker.sv
// Per-frame bounding-box tracker: run-filtered target pixels are accumulated into
// a box and count, then published once per frame with the box centre.
module target_tracker
    import tracker_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int RUN_MIN    = 4,
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             DE,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic             is_target_color,
    output logic             obj_valid,
    output logic             lost,
    output logic             frame_done,
    output logic [9:0]       obj_x_min,
    output logic [9:0]       obj_x_max,
    output logic [9:0]       obj_y_min,
    output logic [9:0]       obj_y_max,
    output logic [9:0]       obj_cx,
    output logic [9:0]       obj_cy,
    output logic [CNT_W-1:0] pix_count
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic coord_t centre(input coord_t lo, input coord_t hi);
        logic [COORD_W:0] s;
        s = {1'b0, lo} + {1'b0, hi};
        return s[COORD_W:1];
    endfunction

    tracker_state_t   state;
    coord_t           acc_x_min, acc_x_max, acc_y_min, acc_y_max;
    logic [CNT_W-1:0] acc_count;
    logic             frame_start, frame_end, filt_en, acc_clear;
    logic             q_first, q_cont;
    coord_t           first_x;

    assign frame_start = pix_en && DE && (x_pixel == '0) && (y_pixel == '0);
    assign frame_end   = pix_en && DE && (x_pixel == coord_t'(H_ACTIVE - 1))
                                      && (y_pixel == coord_t'(V_ACTIVE - 1));
    assign filt_en     = pix_en && ((state == ACCUM) || ((state == IDLE) && frame_start));
    assign acc_clear   = (state == COMMIT) || frame_start;
    assign first_x     = x_pixel - coord_t'(RUN_MIN - 1);

    run_filter #(
        .RUN_MIN (RUN_MIN)
    ) u_run_filter (
        .clk           (clk),
        .reset         (reset),
        .enable        (filt_en),
        .de            (DE),
        .x             (x_pixel),
        .is_target     (is_target_color),
        .qualify_first (q_first),
        .qualify_cont  (q_cont)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_count <= '0;
        end else if (acc_clear) begin
            acc_x_min <= '1;
            acc_x_max <= '0;
            acc_y_min <= '1;
            acc_y_max <= '0;
            acc_count <= '0;
        end else if (q_first) begin
            // The whole run qualifies at once, so its left edge is RUN_MIN-1 back.
            acc_count <= sat_add(acc_count, CNT_W'(RUN_MIN));
            acc_x_min <= (first_x < acc_x_min) ? first_x : acc_x_min;
            acc_x_max <= (x_pixel > acc_x_max) ? x_pixel : acc_x_max;
            acc_y_min <= (y_pixel < acc_y_min) ? y_pixel : acc_y_min;
            acc_y_max <= (y_pixel > acc_y_max) ? y_pixel : acc_y_max;
        end else if (q_cont) begin
            acc_count <= sat_add(acc_count, CNT_W'(1));
            acc_x_max <= (x_pixel > acc_x_max) ? x_pixel : acc_x_max;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            obj_valid  <= 1'b0;
            lost       <= 1'b0;
            frame_done <= 1'b0;
            obj_x_min  <= '0;
            obj_x_max  <= '0;
            obj_y_min  <= '0;
            obj_y_max  <= '0;
            obj_cx     <= '0;
            obj_cy     <= '0;
            pix_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (frame_end && !frame_start) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    frame_done <= 1'b1;
                    state      <= ACCUM;
                    if (acc_count >= CNT_W'(MIN_PIXELS)) begin
                        obj_valid <= 1'b1;
                        lost      <= 1'b0;
                        obj_x_min <= acc_x_min;
                        obj_x_max <= acc_x_max;
                        obj_y_min <= acc_y_min;
                        obj_y_max <= acc_y_max;
                        obj_cx    <= centre(acc_x_min, acc_x_max);
                        obj_cy    <= centre(acc_y_min, acc_y_max);
                        pix_count <= acc_count;
                    end else begin
                        obj_valid <= 1'b0;
                        lost      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_tracker.sv
// Scoreboard bench for target_tracker on a reduced 64x48 raster.
`timescale 1ns/1ps
module tb_target_tracker;

    localparam int H    = 64;
    localparam int V    = 48;
    localparam int RUN  = 4;
    localparam int MINP = 64;
    localparam int CW   = 11;

    localparam int K_RECT  = 0;
    localparam int K_NOISE = 1;
    localparam int K_FULL  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_en;
    logic          DE;
    logic [9:0]    xp;
    logic [9:0]    yp;
    logic          tgt;
    logic          obj_valid, lost, frame_done;
    logic [9:0]    obj_x_min, obj_x_max, obj_y_min, obj_y_max, obj_cx, obj_cy;
    logic [CW-1:0] pix_count;

    typedef struct packed {
        logic          valid;
        logic          lost;
        logic [9:0]    xmin;
        logic [9:0]    xmax;
        logic [9:0]    ymin;
        logic [9:0]    ymax;
        logic [9:0]    cx;
        logic [9:0]    cy;
        logic [CW-1:0] cnt;
        logic [31:0]   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    exp_t got;
    logic pend_valid = 1'b0;
    logic gated      = 1'b0;
    logic prev_fd    = 1'b0;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   commits    = 0;
    int   rx0, rx1, ry0, ry1;

    target_tracker #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .RUN_MIN    (RUN),
        .MIN_PIXELS (MINP),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pix_en          (pix_en),
        .DE              (DE),
        .x_pixel         (xp),
        .y_pixel         (yp),
        .is_target_color (tgt),
        .obj_valid       (obj_valid),
        .lost            (lost),
        .frame_done      (frame_done),
        .obj_x_min       (obj_x_min),
        .obj_x_max       (obj_x_max),
        .obj_y_min       (obj_y_min),
        .obj_y_max       (obj_y_max),
        .obj_cx          (obj_cx),
        .obj_cy          (obj_cy),
        .pix_count       (pix_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every commit pulse is matched against the oldest expected frame.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            commits++;
            check("frame_done_width", 32'(prev_fd), 0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: frame_done at cycle %0d, expected none", cyc);
            end else begin
                got = sb.pop_front();
                check("commit_latency", cyc, got.cyc);
                check("obj_valid", 32'(obj_valid), 32'(got.valid));
                check("lost", 32'(lost), 32'(got.lost));
                check("obj_x_min", 32'(obj_x_min), 32'(got.xmin));
                check("obj_x_max", 32'(obj_x_max), 32'(got.xmax));
                check("obj_y_min", 32'(obj_y_min), 32'(got.ymin));
                check("obj_y_max", 32'(obj_y_max), 32'(got.ymax));
                check("obj_cx", 32'(obj_cx), 32'(got.cx));
                check("obj_cy", 32'(obj_cy), 32'(got.cy));
                check("pix_count", 32'(pix_count), 32'(got.cnt));
            end
        end
        prev_fd = frame_done;
    end

    task automatic expect_frame(input logic v, input logic l, input int xmin, input int xmax,
                                input int ymin, input int ymax, input int cx, input int cy,
                                input int cnt);
        pend.valid = v;
        pend.lost  = l;
        pend.xmin  = 10'(xmin);
        pend.xmax  = 10'(xmax);
        pend.ymin  = 10'(ymin);
        pend.ymax  = 10'(ymax);
        pend.cx    = 10'(cx);
        pend.cy    = 10'(cy);
        pend.cnt   = CW'(cnt);
        pend_valid = 1'b1;
    endtask

    // Drive one clock of inputs; an enabled end pixel releases the pending expectation.
    task automatic put(input logic en, input logic de, input int x, input int y, input logic t);
        pix_en = en;
        DE     = de;
        xp     = 10'(x);
        yp     = 10'(y);
        tgt    = t;
        if (en && de && x == H - 1 && y == V - 1 && pend_valid) begin
            pend.cyc = 32'(cyc + 2);
            sb.push_back(pend);
            pend_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input logic de, input int x, input int y, input logic t);
        put(1'b1, de, x, y, t);
        if (gated) begin
            repeat (3) put(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                           int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end
    endtask

    function automatic logic pix_tgt(input int kind, input int x, input int y);
        case (kind)
            K_RECT:  return (x >= rx0) && (x <= rx1) && (y >= ry0) && (y <= ry1);
            K_NOISE: return ((y % 4 == 0) && (x % 8 < 3)) ||
                            ((y % 4 == 2) && (x % 8 >= 4) && (x % 8 < 7));
            K_FULL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic rows(input int kind, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < H; x++) pixel(1'b1, x, y, pix_tgt(kind, x, y));
            for (int k = 0; k < 3; k++) pixel(1'b0, H + k, y, 1'b1);
        end
    endtask

    task automatic vblank();
        for (int k = 0; k < 2 * (H + 3); k++) pixel(1'b0, H + (k % 4), V + k / (H + 3), 1'b0);
    endtask

    task automatic frame(input int kind);
        rows(kind, 0, V - 1);
        vblank();
        check("queue_drained", sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_obj_valid"}, 32'(obj_valid), 0);
        check({tag, "_lost"}, 32'(lost), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_box"}, {2'b0, obj_x_min, obj_x_max, obj_y_min}, 0);
        check({tag, "_ymax_centre"}, {2'b0, obj_y_max, obj_cx, obj_cy}, 0);
        check({tag, "_pix_count"}, 32'(pix_count), 0);
    endtask

    task automatic set_rect(input int a, input int b, input int c, input int d);
        rx0 = a; rx1 = b; ry0 = c; ry1 = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; pix_en = 1'b0; DE = 1'b0; xp = '0; yp = '0; tgt = 1'b0;
        set_rect(10, 19, 20, 29);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Tail of a frame seen from IDLE: must not commit.
        rows(K_FULL, 40, V - 1);
        vblank();

        expect_frame(1, 0, 10, 19, 20, 29, 14, 24, 100);
        frame(K_RECT);

        expect_frame(0, 1, 10, 19, 20, 29, 14, 24, 100);
        frame(K_NOISE);

        expect_frame(1, 0, 0, 63, 0, 47, 31, 23, 2047);
        frame(K_FULL);

        // Restart: a new frame start while accumulating discards the partial frame.
        rows(K_FULL, 0, 10);
        vblank();
        expect_frame(1, 0, 10, 19, 20, 29, 14, 24, 100);
        frame(K_RECT);

        // Mid-frame reset: remainder of this frame must not commit.
        rows(K_RECT, 0, 23);
        reset = 1'b0;
        #1;
        check_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        check_zero("midreset_hold");
        reset = 1'b1;
        rows(K_RECT, 24, V - 1);
        vblank();
        check("no_commit_after_reset", commits, 4);

        expect_frame(1, 0, 10, 19, 20, 29, 14, 24, 100);
        frame(K_RECT);

        gated = 1'b1;
        set_rect(30, 45, 5, 12);
        expect_frame(1, 0, 30, 45, 5, 12, 37, 8, 128);
        frame(K_RECT);
        gated = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) put(1'b0, 1'b0, 0, 0, 1'b0);
        check("final_queue_empty", sb.size(), 0);
        check("total_commits", commits, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
